// File: rtl/flash_pkg.sv
// Shared flash definitions: macro-op codes, job error codes and sequencer states.
// Used by the job sequencer, the flash FSM and the UART menu logic.
package flash_pkg;

    localparam logic [3:0] MOP_NOP         = 4'h0;
    localparam logic [3:0] MOP_READ        = 4'h3;
    localparam logic [3:0] MOP_READ_STATUS = 4'h5;
    localparam logic [3:0] MOP_WRITE_EN    = 4'h6;
    localparam logic [3:0] MOP_ERASE_4K    = 4'hA;
    localparam logic [3:0] MOP_WRITE_PAGE  = 4'hC;
    localparam logic [3:0] MOP_ERASE_64K   = 4'hD;

    localparam logic [1:0] ERR_OK         = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b01;
    localparam logic [1:0] ERR_MISALIGNED = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CHK       = 4'd1,
        ST_ERS_REQ   = 4'd2,
        ST_ERS_WAIT  = 4'd3,
        ST_WAIT_DATA = 4'd4,
        ST_WR_REQ    = 4'd5,
        ST_WR_WAIT   = 4'd6,
        ST_NEXT      = 4'd7,
        ST_FIN       = 4'd8
    } seq_state_e;

    function automatic logic [31:0] subsector_base(input logic [31:0] addr);
        return {addr[31:12], 12'h000};
    endfunction

    // The job may end exactly at the top of the 4 GB space but not beyond it.
    function automatic logic job_overflows(input logic [31:0] addr, input logic [15:0] pages);
        logic [32:0] end_s;
        end_s = {1'b0, addr} + {9'd0, pages, 8'h00};
        return end_s > 33'h1_0000_0000;
    endfunction

endpackage

// File: rtl/flash_watchdog.sv
// Saturating per-macro-op watchdog. The strobe cycle counts as the first cycle
// of the operation, so expiry lands 2^TIMEOUT_W-1 cycles after the strobe.
module flash_watchdog #(
    parameter int TIMEOUT_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] cnt_q;

    // Cycle counter for the outstanding macro-op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= CNT_ONE;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign expired_o = enable_i && (cnt_q >= (CNT_MAX - CNT_ONE));

endmodule

// File: rtl/flash_job_sequencer.sv
// Breaks a multi-page program job into 4kB erase and 256-byte page-write
// macro-ops for the flash FSM, with abort, watchdog and range checking.
module flash_job_sequencer
    import flash_pkg::*;
#(
    parameter int   TIMEOUT_W = 24,
    parameter logic ERASE_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [15:0] page_count,
    input  logic        abort,
    input  logic        page_ready,
    output logic [3:0]  macro_states,
    output logic        macro_states_valid,
    output logic [63:0] addr_out,
    input  logic        macro_states_done,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [15:0] pages_done
);

    seq_state_e  state_q;
    logic [31:0] cur_addr_q;
    logic [15:0] remaining_q;
    logic [15:0] pages_done_q;
    logic [1:0]  err_q;
    logic        busy_q;
    logic        done_q;
    logic [3:0]  code_q;
    logic        valid_q;
    logic [31:0] addr_q;
    logic        abort_q;

    logic [31:0] next_addr_s;
    logic        in_wait_s;
    logic        expired_s;

    assign next_addr_s = cur_addr_q + 32'h0000_0100;
    assign in_wait_s   = (state_q == ST_ERS_WAIT) || (state_q == ST_WR_WAIT);

    flash_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (valid_q),
        .enable_i (in_wait_s),
        .expired_o(expired_s)
    );

    // Job FSM; all outputs are registered and set on the transition into a state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= 32'h0000_0000;
            remaining_q  <= 16'h0000;
            pages_done_q <= 16'h0000;
            err_q        <= ERR_OK;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            code_q       <= MOP_NOP;
            valid_q      <= 1'b0;
            addr_q       <= 32'h0000_0000;
            abort_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr_q   <= start_addr;
                        remaining_q  <= page_count;
                        pages_done_q <= 16'h0000;
                        err_q        <= ERR_OK;
                        abort_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (cur_addr_q[7:0] != 8'h00) begin
                        err_q   <= ERR_MISALIGNED;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (job_overflows(cur_addr_q, remaining_q)) begin
                        err_q   <= ERR_OVERFLOW;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (remaining_q == 16'h0000) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (ERASE_EN) begin
                        code_q  <= MOP_ERASE_4K;
                        addr_q  <= subsector_base(cur_addr_q);
                        valid_q <= 1'b1;
                        state_q <= ST_ERS_REQ;
                    end else begin
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_ERS_REQ: begin
                    state_q <= ST_ERS_WAIT;
                end
                ST_ERS_WAIT: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (macro_states_done) begin
                        state_q <= ST_WAIT_DATA;
                    end else if (expired_s) begin
                        err_q   <= ERR_TIMEOUT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_WAIT_DATA: begin
                    if (abort || abort_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (page_ready) begin
                        code_q  <= MOP_WRITE_PAGE;
                        addr_q  <= cur_addr_q;
                        valid_q <= 1'b1;
                        state_q <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    state_q <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (macro_states_done) begin
                        state_q <= ST_NEXT;
                    end else if (expired_s) begin
                        err_q   <= ERR_TIMEOUT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_NEXT: begin
                    pages_done_q <= pages_done_q + 16'h0001;
                    remaining_q  <= remaining_q - 16'h0001;
                    cur_addr_q   <= next_addr_s;
                    if ((remaining_q == 16'h0001) || abort_q || abort) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end else if (ERASE_EN && (next_addr_s[11:0] == 12'h000)) begin
                        code_q  <= MOP_ERASE_4K;
                        addr_q  <= subsector_base(next_addr_s);
                        valid_q <= 1'b1;
                        state_q <= ST_ERS_REQ;
                    end else begin
                        state_q <= ST_WAIT_DATA;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign macro_states       = code_q;
    assign macro_states_valid = valid_q;
    assign addr_out           = {32'h0000_0000, addr_q};
    assign busy               = busy_q;
    assign done               = done_q;
    assign err_code           = err_q;
    assign pages_done         = pages_done_q;

endmodule

// File: tb/tb_flash_job_sequencer.sv
// Directed bench: a job-level model predicts the macro-op stream and final status,
// a compare process checks every strobe and done pulse, and literals pin the model.
module tb_flash_job_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'h0;
    logic [15:0] page_count = 16'h0;
    logic        abort = 1'b0;
    logic        page_ready = 1'b0;
    logic        macro_states_done = 1'b0;
    logic [3:0]  macro_states;
    logic        macro_states_valid;
    logic [63:0] addr_out;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [15:0] pages_done;

    flash_job_sequencer #(.TIMEOUT_W(4), .ERASE_EN(1'b1)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .start_addr        (start_addr),
        .page_count        (page_count),
        .abort             (abort),
        .page_ready        (page_ready),
        .macro_states      (macro_states),
        .macro_states_valid(macro_states_valid),
        .addr_out          (addr_out),
        .macro_states_done (macro_states_done),
        .busy              (busy),
        .done              (done),
        .err_code          (err_code),
        .pages_done        (pages_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] addr;
    } op_t;

    op_t        exp_q[$];
    logic [1:0] exp_err = 2'b00;
    int         exp_pages = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         strobes = 0;
    int         first_strobe_cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    bit         done_seen = 1'b0;
    int         resp_delay = 5;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Job-level model: list of expected macro-ops plus final status.
    task automatic plan_job(input logic [31:0] a, input int cnt, input int limit);
        longint end_l;
        logic [31:0] pa;
        exp_q.delete();
        end_l = longint'(a) + 256 * longint'(cnt);
        exp_pages = 0;
        if (a[7:0] != 8'h00) begin
            exp_err = 2'b10;
        end else if (end_l > 64'h1_0000_0000) begin
            exp_err = 2'b11;
        end else begin
            exp_err = 2'b00;
            exp_pages = (cnt < limit) ? cnt : limit;
            for (int p = 0; p < exp_pages; p++) begin
                pa = a + 32'(p * 256);
                if (p == 0 || pa[11:0] == 12'h000)
                    exp_q.push_back('{4'hA, pa & 32'hFFFF_F000});
                exp_q.push_back('{4'hC, pa});
            end
        end
    endtask

    // Compare process: every strobe against the model queue, every done against final status.
    always @(negedge clk) begin
        op_t o;
        if (!rst) begin
            if (macro_states_valid) begin
                strobes++;
                if (strobes == 1) first_strobe_cyc = cyc;
                check("addr_hi", {32'h0, addr_out[63:32]}, 64'h0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got code %h addr %h, expected none",
                             macro_states, addr_out);
                end else begin
                    o = exp_q.pop_front();
                    check("op_code", {60'h0, macro_states}, {60'h0, o.code});
                    check("op_addr", {32'h0, addr_out[31:0]}, {32'h0, o.addr});
                end
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check("done_err", {62'h0, err_code}, {62'h0, exp_err});
                check("done_pages", {48'h0, pages_done}, 64'(exp_pages));
                check("done_busy", {63'h0, busy}, 64'h0);
                check("ops_left", 64'(exp_q.size()), 64'h0);
            end
        end
    end

    // Flash FSM stand-in: completion pulse resp_delay cycles after each strobe (0 = never).
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            macro_states_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (macro_states_valid) begin
                cnt = resp_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) macro_states_done = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] c);
        strobes    = 0;
        done_seen  = 1'b0;
        start_addr = a;
        page_count = c;
        start      = 1'b1;
        start_cyc  = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done_seen && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected done", name, budget);
        end
        tick(1);
    endtask

    task automatic wait_strobes(input int n);
        int k;
        k = 0;
        while (strobes < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("strobe_wait", 64'(strobes), 64'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"},  {60'h0, macro_states}, 64'h0);
        check({tag, "_valid"}, {63'h0, macro_states_valid}, 64'h0);
        check({tag, "_addr"},  addr_out, 64'h0);
        check({tag, "_busy"},  {63'h0, busy}, 64'h0);
        check({tag, "_done"},  {63'h0, done}, 64'h0);
        check({tag, "_err"},   {62'h0, err_code}, 64'h0);
        check({tag, "_pages"}, {48'h0, pages_done}, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // 17 pages from 0x1000: two subsector erases, stray start while busy ignored.
        resp_delay = 5;
        page_ready = 1'b1;
        plan_job(32'h0000_1000, 17, 17);
        do_start(32'h0000_1000, 16'd17);
        tick(4);
        start_addr = 32'h0000_9000;
        page_count = 16'd1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("long_job", 1000);
        check("long_first_latency", 64'(first_strobe_cyc - start_cyc), 64'd2);
        check("long_strobes", 64'(strobes), 64'd19);
        check("long_pages_lit", {48'h0, pages_done}, 64'd17);
        check("long_err_lit", {62'h0, err_code}, 64'd0);
        tick(2);
        check("long_idle_busy", {63'h0, busy}, 64'h0);
        check("long_held_pages", {48'h0, pages_done}, 64'd17);

        // Misaligned start.
        plan_job(32'h0000_0080, 3, 3);
        do_start(32'h0000_0080, 16'd3);
        wait_done("misaligned", 20);
        check("mis_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        check("mis_strobes", 64'(strobes), 64'd0);
        check("mis_err_lit", {62'h0, err_code}, 64'h2);

        // Overflow past 4 GB, then the exact-fit boundary.
        plan_job(32'hFFFF_FF00, 2, 2);
        do_start(32'hFFFF_FF00, 16'd2);
        wait_done("overflow", 20);
        check("ovf_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        check("ovf_strobes", 64'(strobes), 64'd0);
        check("ovf_err_lit", {62'h0, err_code}, 64'h3);

        plan_job(32'hFFFF_FF00, 1, 1);
        do_start(32'hFFFF_FF00, 16'd1);
        wait_done("top_fit", 100);
        check("fit_strobes", 64'(strobes), 64'd2);
        check("fit_pages_lit", {48'h0, pages_done}, 64'd1);

        // Watchdog: flash never completes the erase.
        resp_delay = 0;
        plan_job(32'h0000_3000, 2, 0);
        exp_q.push_back('{4'hA, 32'h0000_3000});
        exp_err = 2'b01;
        do_start(32'h0000_3000, 16'd2);
        wait_done("timeout", 100);
        check("to_done_after_strobe", 64'(done_cyc - first_strobe_cyc), 64'd15);
        check("to_err_lit", {62'h0, err_code}, 64'h1);
        check("to_pages_lit", {48'h0, pages_done}, 64'd0);
        resp_delay = 5;

        // Abort raised while the 2nd write is outstanding.
        plan_job(32'h0000_5000, 4, 2);
        do_start(32'h0000_5000, 16'd4);
        wait_strobes(3);
        tick(1);
        abort = 1'b1;
        wait_done("abort_wr", 100);
        abort = 1'b0;
        check("abort_pages_lit", {48'h0, pages_done}, 64'd2);
        check("abort_err_lit", {62'h0, err_code}, 64'h0);

        // Page data arrives late: no write strobe until page_ready.
        page_ready = 1'b0;
        plan_job(32'h0000_6100, 2, 2);
        do_start(32'h0000_6100, 16'd2);
        tick(20);
        check("gap_strobes", 64'(strobes), 64'd1);
        check("gap_busy", {63'h0, busy}, 64'h1);
        page_ready = 1'b1;
        wait_done("gap", 100);
        check("gap_pages_lit", {48'h0, pages_done}, 64'd2);

        // Abort while waiting for data after the first erase.
        page_ready = 1'b0;
        plan_job(32'h0000_7000, 3, 0);
        exp_q.push_back('{4'hA, 32'h0000_7000});
        do_start(32'h0000_7000, 16'd3);
        tick(12);
        abort = 1'b1;
        wait_done("abort_wd", 50);
        abort = 1'b0;
        page_ready = 1'b1;
        check("abwd_strobes", 64'(strobes), 64'd1);
        check("abwd_pages_lit", {48'h0, pages_done}, 64'd0);

        // Reset mid-write, then an empty job.
        plan_job(32'h0000_8000, 3, 3);
        do_start(32'h0000_8000, 16'd3);
        wait_strobes(2);
        tick(1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        done_seen = 1'b0;
        tick(3);
        check("midrst_no_done", {63'h0, done_seen}, 64'h0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        plan_job(32'h0000_0000, 0, 0);
        do_start(32'h0000_0000, 16'd0);
        wait_done("empty", 20);
        check("empty_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        check("empty_strobes", 64'(strobes), 64'd0);
        check("empty_err_lit", {62'h0, err_code}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flash_job_sequencer.md
FLASH_JOB_SEQUENCER -- requirements
Module: flash_job_sequencer

Interface
REQ-001 Parameter TIMEOUT_W, default 24: width of the per-macro-op watchdog counter; timeout fires at 2^TIMEOUT_W-1 cycles.
REQ-002 Parameter ERASE_EN, default 1: 1 inserts 4kB subsector erases before programming; 0 programs only.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle job request; sampled only when busy=0.
REQ-006 start_addr  in  32  first flash byte address of job.
REQ-007 page_count  in  16  number of 256-byte pages to program.
REQ-008 abort  in  1  level; requests job termination.
REQ-009 page_ready  in  1  upstream page buffer holds at least 256 bytes.
REQ-010 macro_states  out  4  macro-op code to flash FSM (4'hA erase 4kB, 4'hC write page).
REQ-011 macro_states_valid  out  1  one-cycle macro-op issue strobe.
REQ-012 addr_out  out  64  macro-op address; bits 63:32 always 0.
REQ-013 macro_states_done  in  1  flash FSM completion pulse.
REQ-014 busy  out  1  job in progress.
REQ-015 done  out  1  one-cycle pulse at job end (success, abort or error).
REQ-016 err_code  out  2  00 ok, 01 timeout, 10 misaligned, 11 address overflow; held until next accepted start.
REQ-017 pages_done  out  16  pages completed in current/last job.

Function
REQ-018 States: IDLE, CHK, ERS_REQ, ERS_WAIT, WAIT_DATA, WR_REQ, WR_WAIT, NEXT, FIN.
REQ-019 IDLE: start=1 latches start_addr into cur_addr and page_count into remaining, clears pages_done and err_code, sets busy, goes CHK.
REQ-020 CHK: start_addr[7:0]!=0 -> err 10, FIN; start_addr+256*page_count > 2^32 (33-bit compare) -> err 11, FIN; remaining=0 -> FIN with err 00; else -> ERS_REQ if erase needed, else WAIT_DATA.
REQ-021 Erase needed when ERASE_EN=1 and (first page of job, or cur_addr[11:0]=0); erase address = {cur_addr[31:12],12'h000}.
REQ-022 ERS_REQ: drive macro_states=4'hA, addr_out, macro_states_valid=1 for exactly one cycle; -> ERS_WAIT.
REQ-023 ERS_WAIT: macro_states_done -> WAIT_DATA; watchdog expiry -> err 01, FIN.
REQ-024 WAIT_DATA: abort=1 -> FIN (err 00); page_ready=1 -> WR_REQ; no timeout here.
REQ-025 WR_REQ: macro_states=4'hC, addr_out=cur_addr, valid one cycle; -> WR_WAIT.
REQ-026 WR_WAIT: macro_states_done -> NEXT; watchdog expiry -> err 01, FIN.
REQ-027 NEXT: pages_done+1, remaining-1, cur_addr+256; remaining was 1 or abort pending -> FIN; else erase needed -> ERS_REQ, else WAIT_DATA.
REQ-028 abort seen in ERS_WAIT/WR_WAIT is latched and honoured at the next WAIT_DATA or NEXT; an issued macro-op is never abandoned except by timeout.
REQ-029 FIN: done=1 one cycle, busy=0, -> IDLE; start in FIN cycle ignored.
REQ-030 Watchdog cleared on every valid strobe; counts only in ERS_WAIT/WR_WAIT; saturating.
REQ-031 macro_states_done outside a WAIT state ignored.
REQ-032 Latency: start at cycle N -> first macro_states_valid at N+2 (erase path) or N+2+wait for page_ready (no-erase).
REQ-033 macro_states holds last issued code between strobes; addr_out likewise.

Reset
REQ-034 rst asserted: state IDLE; macro_states=0, macro_states_valid=0, addr_out=0, busy=0, done=0, err_code=00, pages_done=0, watchdog 0, abort latch 0.
REQ-035 rst mid-job abandons job immediately; no done pulse emitted.

Structure
REQ-036 Macro-op codes (4'hA, 4'hC, others in the family) and err_code values live in shared package flash_pkg, used also by the flash FSM and UART menu logic.
REQ-037 Watchdog may be sub-module flash_watchdog (clear, enable, expired); otherwise single flat module.

Verification
REQ-038 start_addr=0x0000_1000, page_count=17, page_ready=1, done after 5 cycles -> erase@0x1000, 16 writes, erase@0x2000, write@0x2000; done, pages_done=17, err 00.
REQ-039 start_addr=0x0000_0080 -> no valid strobe, done 2 cycles after start, err 10.
REQ-040 start_addr=0xFFFF_FF00, page_count=2 -> err 11, no macro-op.
REQ-041 TIMEOUT_W=4, macro_states_done never asserted -> done 15 cycles after erase strobe, err 01, pages_done=0.
REQ-042 page_count=4, abort raised during 2nd WR_WAIT -> 2nd write completes, done, pages_done=2, err 00.
REQ-043 rst asserted in WR_WAIT, then new start with page_count=0 -> outputs at reset values, then done 2 cycles after start, no strobe.
